// File: rtl/imm_ext_pkg.sv
// Shared extension-mode encoding for the immediate extension datapath.
package imm_ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_SIGN   = 2'b00;
    localparam ext_mode_t EXT_ZERO   = 2'b01;
    localparam ext_mode_t EXT_UPPER  = 2'b10;
    localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI-style) and
// branch-offset (sign-extend, then shift left by 2) modes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] uext;
    logic [OUT_W-1:0] bext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
    // The immediate lands in the top IN_W bits; with OUT_W < 2*IN_W
    // this is simply the low OUT_W bits of imm << (OUT_W-IN_W).
    assign uext = {imm, {(OUT_W-IN_W){1'b0}}};
    // Branch offsets are word offsets: drop the two top bits of the
    // sign-extended value and force the two LSBs to zero.
    assign bext = {sext[OUT_W-3:0], 2'b00};

    // Select the extension for the requested mode.
    always_comb begin
        ext = sext;
        case (mode)
            EXT_SIGN:   ext = sext;
            EXT_ZERO:   ext = zext;
            EXT_UPPER:  ext = uext;
            EXT_BRANCH: ext = bext;
            default:    ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Buffered immediate extender: extension on the way in, DEPTH-entry FIFO
// with valid/ready on both sides so decode can absorb stalls.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter  int IN_W  = 16,
    parameter  int OUT_W = 32,
    parameter  int DEPTH = 2,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [IN_W-1:0]  InImm,
    input  logic [1:0]       InMode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OUT_W-1:0] OutData,
    output logic [LVL_W-1:0] Level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] lvl;
    logic [OUT_W-1:0] ext_val;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (InImm),
        .mode (InMode),
        .ext  (ext_val)
    );

    // Status comes from the registered level only, so a full FIFO refuses
    // a push even while it is being popped in the same cycle.
    assign InReady  = (lvl != LVL_FULL);
    assign OutValid = (lvl != '0);
    assign OutData  = mem[rd_ptr];
    assign Level    = lvl;

    assign push = InValid && InReady;
    assign pop  = OutValid && OutReady;

    // Storage write and write-pointer advance with explicit wrap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= ext_val;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
    end

    // Read-pointer advance on pop with explicit wrap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: up on push-only, down on pop-only, held otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lvl <= '0;
        end else if (push && !pop) begin
            lvl <= lvl + LVL_W'(1);
        end else if (pop && !push) begin
            lvl <= lvl - LVL_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default-parameter instance (a) and an
// IN_W=8/OUT_W=16/DEPTH=3 instance (b), scoreboarded by expected-value queues.
module tb_imm_extend_pipe;

    logic clk;
    logic rst_n;

    logic        a_valid, a_irdy, a_ovalid, a_ordy;
    logic [15:0] a_imm;
    logic [1:0]  a_mode;
    logic [31:0] a_odata, a_exp;
    logic [1:0]  a_level;

    logic        b_valid, b_irdy, b_ovalid, b_ordy;
    logic [7:0]  b_imm;
    logic [1:0]  b_mode;
    logic [15:0] b_odata, b_exp;
    logic [1:0]  b_level;

    logic [31:0] q_a[$];
    logic [15:0] q_b[$];

    int checks;
    int failures;

    imm_extend_pipe dut_a (
        .Clk(clk), .Reset_n(rst_n),
        .InValid(a_valid), .InReady(a_irdy), .InImm(a_imm), .InMode(a_mode),
        .OutValid(a_ovalid), .OutReady(a_ordy), .OutData(a_odata), .Level(a_level)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .DEPTH(3)) dut_b (
        .Clk(clk), .Reset_n(rst_n),
        .InValid(b_valid), .InReady(b_irdy), .InImm(b_imm), .InMode(b_mode),
        .OutValid(b_ovalid), .OutReady(b_ordy), .OutData(b_odata), .Level(b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: arithmetic on 64-bit values, masked to OUT_W.
    function automatic logic [63:0] model(input logic [63:0] x_in, input logic [1:0] m,
                                          input int iw, input int ow);
        logic [63:0] x, s, r;
        x = x_in & ((64'd1 << iw) - 64'd1);
        s = x;
        if (x[iw-1]) s = x | ~((64'd1 << iw) - 64'd1);
        case (m)
            2'b00:   r = s;
            2'b01:   r = x;
            2'b10:   r = x << (ow - iw);
            default: r = s << 2;
        endcase
        return r & ((64'd1 << ow) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called while clk is low: score handshakes that will fire at the next
    // rising edge, then advance to the following falling edge.
    task automatic tick();
        logic [31:0] ea;
        logic [15:0] eb;
        if (a_ovalid && a_ordy) begin
            if (q_a.size() == 0) chk("a_unexpected_pop", 32'd1, 32'd0);
            else begin
                ea = q_a.pop_front();
                chk("a_data", a_odata, ea);
            end
        end
        if (a_valid && a_irdy) q_a.push_back(a_exp);
        if (b_ovalid && b_ordy) begin
            if (q_b.size() == 0) chk("b_unexpected_pop", 32'd1, 32'd0);
            else begin
                eb = q_b.pop_front();
                chk("b_data", 32'(b_odata), 32'(eb));
            end
        end
        if (b_valid && b_irdy) q_b.push_back(b_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_a(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
        a_ordy  = 1'b1;
        a_valid = 1'b1; a_imm = imm; a_mode = mode; a_exp = exp;
        tick();
        a_valid = 1'b0;
        chk("a_latency_valid", 32'(a_ovalid), 32'd1);
        chk("a_latency_data", a_odata, exp);
        tick();
        chk("a_level_after_pop", 32'(a_level), 32'd0);
    endtask

    task automatic send_b(input logic [7:0] imm, input logic [1:0] mode, input logic [15:0] exp);
        b_ordy  = 1'b1;
        b_valid = 1'b1; b_imm = imm; b_mode = mode; b_exp = exp;
        tick();
        b_valid = 1'b0;
        chk("b_latency_valid", 32'(b_ovalid), 32'd1);
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        a_valid = 0; a_imm = '0; a_mode = '0; a_ordy = 0; a_exp = '0;
        b_valid = 0; b_imm = '0; b_mode = '0; b_ordy = 0; b_exp = '0;
        #1;
        chk("rst_a_level", 32'(a_level), 32'd0);
        chk("rst_a_ovalid", 32'(a_ovalid), 32'd0);
        chk("rst_a_irdy", 32'(a_irdy), 32'd1);
        chk("rst_a_odata", a_odata, 32'd0);
        chk("rst_b_level", 32'(b_level), 32'd0);
        chk("rst_b_irdy", 32'(b_irdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Each mode on its own, consumer always ready.
        send_a(16'h9000, 2'b00, 32'hFFFF9000);
        send_a(16'h0004, 2'b00, 32'h00000004);
        send_a(16'hF000, 2'b01, 32'h0000F000);
        send_a(16'h1234, 2'b10, 32'h12340000);
        send_a(16'hFFFF, 2'b11, 32'hFFFFFFFC);
        send_a(16'h0004, 2'b11, 32'h00000010);

        // Backpressure: fill, hold the third producer, check head stability.
        a_ordy = 1'b0;
        a_valid = 1'b1; a_imm = 16'h7000; a_mode = 2'b00; a_exp = 32'h00007000;
        tick();
        a_imm = 16'h0001; a_mode = 2'b01; a_exp = 32'h00000001;
        tick();
        chk("bp_level_full", 32'(a_level), 32'd2);
        chk("bp_inready_low", 32'(a_irdy), 32'd0);
        a_imm = 16'h8000; a_mode = 2'b00; a_exp = 32'hFFFF8000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_head_stable", a_odata, 32'h00007000);
            chk("bp_level_held", 32'(a_level), 32'd2);
        end
        a_ordy = 1'b1;
        tick();
        chk("bp_level_after_pop", 32'(a_level), 32'd1);
        tick();
        a_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(a_level), 32'd0);

        // Push and pop together at level 1: level holds, order kept.
        a_ordy = 1'b0;
        a_valid = 1'b1; a_imm = 16'h0011; a_mode = 2'b00; a_exp = 32'h00000011;
        tick();
        a_ordy = 1'b1;
        a_imm = 16'h8022; a_mode = 2'b01; a_exp = 32'h00008022;
        tick();
        chk("pp_level1_hold", 32'(a_level), 32'd1);
        chk("pp_level1_head", a_odata, 32'h00008022);
        a_valid = 1'b0;
        tick();

        // Push and pop together at level 2: push refused, level drops to 1.
        a_ordy = 1'b0;
        a_valid = 1'b1; a_imm = 16'h0100; a_mode = 2'b10; a_exp = 32'h01000000;
        tick();
        a_imm = 16'h0003; a_mode = 2'b11; a_exp = 32'h0000000C;
        tick();
        a_ordy = 1'b1;
        a_imm = 16'hFFFE; a_mode = 2'b00; a_exp = 32'hFFFFFFFE;
        tick();
        chk("pp_level2_drop", 32'(a_level), 32'd1);
        tick();
        a_valid = 1'b0;
        tick();
        chk("pp_level2_drained", 32'(a_level), 32'd0);

        // Asynchronous reset between edges with two entries queued.
        a_ordy = 1'b0;
        a_valid = 1'b1; a_imm = 16'h0055; a_mode = 2'b01; a_exp = 32'h00000055;
        tick();
        a_imm = 16'h0066; a_exp = 32'h00000066;
        tick();
        a_valid = 1'b0;
        chk("ar_level_before", 32'(a_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ovalid", 32'(a_ovalid), 32'd0);
        chk("ar_level", 32'(a_level), 32'd0);
        chk("ar_inready", 32'(a_irdy), 32'd1);
        chk("ar_odata", a_odata, 32'd0);
        q_a.delete();
        #1 rst_n = 1'b1;
        send_a(16'h9000, 2'b00, 32'hFFFF9000);

        // Narrow instance: modes, fill to DEPTH=3, then wrap traffic.
        send_b(8'h80, 2'b00, 16'hFF80);
        send_b(8'hAB, 2'b10, 16'hAB00);
        b_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            b_imm = 8'(8'h90 + i); b_mode = 2'(i);
            b_exp = 16'(model(64'(b_imm), b_mode, 8, 16));
            tick();
        end
        chk("b_level_full", 32'(b_level), 32'd3);
        chk("b_inready_full", 32'(b_irdy), 32'd0);
        b_ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_valid = 1'b1;
            b_imm = 8'($urandom_range(0, 255)); b_mode = 2'($urandom_range(0, 3));
            b_exp = 16'(model(64'(b_imm), b_mode, 8, 16));
            tick();
        end
        b_valid = 1'b0;

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            tick();
        end
        chk("drain_a_empty", 32'(q_a.size()), 32'd0);
        chk("drain_b_empty", 32'(q_b.size()), 32'd0);
        chk("end_b_level", 32'(b_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, buffered successor to the datapath sign-extension unit.
- Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI) or branch-offset (sign-extend then shift left 2).
- Results pass through a DEPTH-entry FIFO with valid/ready handshakes on both sides, so the decode stage can place the block between pipeline registers and tolerate stalls.

Parameters:
- IN_W, 16, immediate input width; must be >= 2.
- OUT_W, 32, extended output width; must be >= IN_W+2.
- DEPTH, 2, FIFO entries; must be >= 1. Power of two is not required.
- LVL_W, $clog2(DEPTH+1), width of the Level output (derived; not overridden).

Ports:
- Clk  in  1  single clock; rising edge active.
- Reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  producer has an immediate.
- InReady  out  1  block can accept.
- InImm  in  IN_W  raw immediate.
- InMode  in  2  00 sign, 01 zero, 10 upper, 11 branch.
- OutValid  out  1  head entry valid.
- OutReady  in  1  consumer accepts head.
- OutData  out  OUT_W  extended value at FIFO head.
- Level  out  LVL_W  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset values (asserted immediately, no clock edge needed): Level=0, read and write pointers 0, all storage 0, OutValid=0, OutData=0, InReady=1. Deassertion is synchronised externally; the block only samples Reset_n asynchronously.
- Push: occurs when InValid && InReady at a rising edge. The extension is computed combinationally from InImm/InMode, and the result is stored at the write pointer.
- Pop: occurs when OutValid && OutReady at a rising edge. The read pointer advances.
- Status signals:
  - InReady = (Level != DEPTH), registered-derived. It does not depend combinationally on OutReady, so a full FIFO rejects a push even when a pop occurs in the same cycle.
  - OutValid = (Level != 0).
  - OutData = storage[read pointer]. It is 0-filled storage when empty; consumers must ignore it.
- Latency: a push into an empty FIFO gives OutValid=1 and the correct OutData in the following cycle (1-cycle latency). There is no bypass path.
- Level update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Pointers: wrap from DEPTH-1 to 0 using an explicit compare, not natural overflow.
- Order: strictly FIFO. InMode is captured with InImm, and the mode of each entry is fixed at push.
- Extension rules (x = InImm, E = OUT_W, I = IN_W):
  - sign: {(E-I){x[I-1]}, x}
  - zero: {(E-I){1'b0}, x}
  - upper: {x, (E-I){1'b0}}; for E < 2I the upper bits truncate. With the defaults this equals LUI: x<<16.
  - branch: the sign-extended value shifted left 2, keeping the low E bits; the two LSBs are 0.
- Protocol rules:
  - InValid while InReady=0 is a legal stall. The producer holds its data.
  - OutData must remain stable while OutValid=1 and OutReady=0.
- Reset mid-operation: all queued entries are discarded. No partial state survives. The first push after reset appears at the head.

Decomposition:
- Shared package imm_ext_pkg holds:
  - mode constants EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11
  - a 2-bit ext_mode_t typedef.
- One combinational sub-module, imm_ext_core, parametrised by IN_W/OUT_W. Inputs: imm and mode. Output: the extended value.
- Top level holds the FIFO storage, pointers, Level counter and handshake logic.

Test Plan:
- Modes, one at a time, with OutReady=1 (defaults):
  - sign 16'h9000 -> OutData 32'hFFFF9000, 1 cycle after push.
  - sign 16'h0004 -> 32'h00000004.
  - zero 16'hF000 -> 32'h0000F000.
  - upper 16'h1234 -> 32'h12340000.
  - branch 16'hFFFF -> 32'hFFFFFFFC.
  - branch 16'h0004 -> 32'h00000010.
- Backpressure: OutReady=0, offer 16'h7000 (sign), 16'h0001 (zero), 16'h8000 (sign) -> Level=2 and InReady=0 after two pushes; the third producer is held. Then OutReady=1 -> outputs 32'h00007000, 32'h00000001, 32'hFFFF8000 in order, with OutData stable throughout the stall.
- Simultaneous push and pop:
  - at Level=1 -> Level stays 1, and the new entry follows the old one.
  - at Level=2 -> push rejected (InReady=0), Level becomes 1.
- Asynchronous reset mid-operation: with Level=2, drive Reset_n=0 between clock edges -> OutValid=0, Level=0 and InReady=1 before the next edge. After release, push 16'h9000 sign -> first output 32'hFFFF9000.
- Parameter variant IN_W=8, OUT_W=16, DEPTH=3:
  - sign 8'h80 -> 16'hFF80.
  - upper 8'hAB -> 16'hAB00.
  - Three pushes with OutReady=0 fill the FIFO (Level=3); pointer wrap is verified over 10 push/pop cycles with no data loss.
